// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART command-frame sequencer.
package uart_frame_pkg;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_COMMIT
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port for the DATA phase, combinational read for COMMIT.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [IW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART command-frame sequencer: parses SOF/ADDR/LEN/payload/XOR frames and
// replays a verified payload as back-to-back register writes.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int CLOCK_SPEED   = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int TIMEOUT_BYTES = 4,
    parameter int MAX_LEN       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    // state     | meaning
    // ST_IDLE   | hunting for SOF, other bytes ignored
    // ST_ADDR   | expecting base address byte
    // ST_LEN    | expecting payload length byte
    // ST_DATA   | buffering payload bytes
    // ST_CHK    | expecting XOR checksum byte
    // ST_COMMIT | replaying buffer as one write per cycle

    localparam int LIMIT = TIMEOUT_BYTES * 10 * (CLOCK_SPEED / BAUD_RATE);
    localparam int TW    = $clog2(LIMIT + 1);
    localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Loaded so the error pulse lands exactly LIMIT cycles after the last byte.
    localparam logic [TW-1:0] TMR_LOAD = TW'(LIMIT - 2);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    state_t        state, state_nxt;
    logic [7:0]    base_addr, len_r, chk, idx;
    logic [TW-1:0] tmr;
    logic          counting, tmo, byte_ok, last_idx, buf_we, err_set;
    logic [1:0]    err_val;
    logic [7:0]    buf_rdata;

    assign counting = state inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    assign tmo      = counting && (tmr == '0);
    assign byte_ok  = rx_valid && !tmo;
    assign last_idx = (idx == len_r - 8'd1);

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        err_val   = ERR_LEN;
        buf_we    = 1'b0;
        if (tmo) begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
            err_val   = ERR_TMO;
        end else begin
            unique case (state)
                ST_IDLE:   if (rx_valid && rx_data == SOF) state_nxt = ST_ADDR;
                ST_ADDR:   if (rx_valid) state_nxt = ST_LEN;
                ST_LEN: begin
                    if (rx_valid) begin
                        if (rx_data == 8'd0 || rx_data > LEN_MAX) begin
                            state_nxt = ST_IDLE;
                            err_set   = 1'b1;
                            err_val   = ERR_LEN;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        buf_we = 1'b1;
                        if (last_idx) state_nxt = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk) begin
                            state_nxt = ST_COMMIT;
                        end else begin
                            state_nxt = ST_IDLE;
                            err_set   = 1'b1;
                            err_val   = ERR_CHK;
                        end
                    end
                end
                ST_COMMIT: if (last_idx) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            len_r     <= '0;
            chk       <= '0;
            idx       <= '0;
            tmr       <= '0;
            drop_cnt  <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
        end else begin
            state     <= state_nxt;
            frame_err <= err_set;
            if (err_set) err_code <= err_val;

            if (state == ST_IDLE)  tmr <= TMR_LOAD;
            else if (counting)     tmr <= rx_valid ? TMR_LOAD : tmr - TMR_ONE;

            if (state == ST_IDLE) idx <= '0;
            if (state == ST_ADDR && byte_ok) begin
                base_addr <= rx_data;
                chk       <= rx_data;
            end
            if (state == ST_LEN && byte_ok) begin
                len_r <= rx_data;
                chk   <= chk ^ rx_data;
            end
            if (state == ST_DATA && byte_ok) begin
                chk <= chk ^ rx_data;
                idx <= last_idx ? 8'd0 : idx + 8'd1;
            end
            if (state == ST_COMMIT) begin
                idx <= idx + 8'd1;
                if (rx_valid && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .IW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[IW-1:0]),
        .wdata (rx_data),
        .raddr (idx[IW-1:0]),
        .rdata (buf_rdata)
    );

    assign busy     = (state != ST_IDLE);
    assign wr_en    = (state == ST_COMMIT);
    assign frame_ok = wr_en && last_idx;
    assign wr_addr  = wr_en ? base_addr + idx : 8'd0;
    assign wr_data  = wr_en ? buf_rdata : 8'd0;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl against a frame-level reference model.
module tb_uart_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int LIMIT   = 4 * 10 * (1000 / 100);

    typedef logic [7:0] bq_t [$];

    logic       clk = 0;
    logic       rst = 0;
    logic       rx_valid = 0;
    logic [7:0] rx_data = 0;
    logic       wr_en, frame_ok, frame_err, busy;
    logic [7:0] wr_addr, wr_data, drop_cnt;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    uart_frame_ctrl #(
        .CLOCK_SPEED   (1000),
        .BAUD_RATE     (100),
        .TIMEOUT_BYTES (4),
        .MAX_LEN       (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: collects frame bytes, judges the whole frame at its
    // end, and produces a queue of pending writes to be issued one per cycle.
    bit         m_coll = 0;
    int         m_gap = 0;
    logic [7:0] fq[$];
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    bit         e_err = 0;
    int         e_code = 0;
    int         e_drop = 0;

    task automatic m_abort(input int code);
        m_coll = 0;
        e_err  = 1;
        e_code = code;
    endtask

    task automatic m_frame_byte();
        int n;
        logic [7:0] x;
        n = fq.size();
        if (n == 2 && (fq[1] == 0 || fq[1] > MAX_LEN)) begin
            m_abort(1);
        end else if (n >= 3 && n == int'(fq[1]) + 3) begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x = x ^ fq[i];
            if (x == fq[n-1]) begin
                for (int i = 0; i < int'(fq[1]); i++) begin
                    wa.push_back(8'(fq[0] + 8'(i)));
                    wd.push_back(fq[2+i]);
                end
                m_coll = 0;
            end else begin
                m_abort(2);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_coll = 0; m_gap = 0; fq.delete(); wa.delete(); wd.delete();
            e_err = 0; e_code = 0; e_drop = 0;
        end else begin
            e_err = 0;
            if (wa.size() > 0) begin
                if (rx_valid && e_drop != 255) e_drop++;
                void'(wa.pop_front());
                void'(wd.pop_front());
            end else if (!m_coll) begin
                if (rx_valid && rx_data == 8'hA5) begin
                    m_coll = 1; m_gap = 0; fq.delete();
                end
            end else begin
                m_gap++;
                if (m_gap == LIMIT - 1) m_abort(3);
                else if (rx_valid) begin
                    m_gap = 0;
                    fq.push_back(rx_data);
                    m_frame_byte();
                end
            end
        end
    end

    // Per-cycle comparison plus logs for the literal checks.
    int log_a[$], log_d[$], log_c[$];
    int n_ok = 0, n_err = 0, last_rx = 0, err_gap = 0;

    always @(negedge clk) begin
        check("busy", busy, int'(m_coll || wa.size() > 0));
        check("wr_en", wr_en, int'(wa.size() > 0));
        check("wr_addr", wr_addr, wa.size() > 0 ? int'(wa[0]) : 0);
        check("wr_data", wr_data, wd.size() > 0 ? int'(wd[0]) : 0);
        check("frame_ok", frame_ok, int'(wa.size() == 1));
        check("frame_err", frame_err, int'(e_err));
        check("err_code", err_code, e_code);
        check("drop_cnt", drop_cnt, e_drop);
        if (wr_en) begin
            log_a.push_back(wr_addr); log_d.push_back(wr_data); log_c.push_back(cyc);
        end
        if (frame_ok) n_ok++;
        if (frame_err) begin
            n_err++;
            err_gap = cyc - last_rx;
        end
        if (rx_valid) last_rx = cyc;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) begin
            rx_valid = 1;
            rx_data  = q[i];
            @(posedge clk);
            #1;
            rx_valid = 0;
        end
    endtask

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log_c.delete();
        n_ok = 0; n_err = 0;
    endtask

    initial begin
        idle(3);
        rst = 1;
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_code", err_code, 0);
        idle(2);

        clear_logs();
        send_seq('{8'h33, 8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
        idle(6);
        check("f1_nwr", log_a.size(), 2);
        check("f1_a0", log_a[0], 8'h10);
        check("f1_d0", log_d[0], 8'h11);
        check("f1_a1", log_a[1], 8'h11);
        check("f1_d1", log_d[1], 8'h22);
        check("f1_b2b", log_c[1] - log_c[0], 1);
        check("f1_ok", n_ok, 1);

        clear_logs();
        send_seq('{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC});
        idle(6);
        check("wrap_a0", log_a[0], 8'hFF);
        check("wrap_d0", log_d[0], 8'hAA);
        check("wrap_a1", log_a[1], 8'h00);
        check("wrap_d1", log_d[1], 8'hBB);
        check("wrap_err", n_err, 0);

        clear_logs();
        send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
        idle(4);
        check("badchk_nwr", log_a.size(), 0);
        check("badchk_code", err_code, 2);
        send_seq('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
        idle(6);
        check("after_chk_nwr", log_a.size(), 2);

        clear_logs();
        send_seq('{8'hA5, 8'h10, 8'h00});
        idle(4);
        check("len0_code", err_code, 1);
        send_seq('{8'hA5, 8'h10, 8'h11});
        idle(4);
        check("len17_code", err_code, 1);
        check("len_nerr", n_err, 2);
        check("len_nwr", log_a.size(), 0);

        clear_logs();
        send_seq('{8'hA5, 8'h20, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20});
        send_seq('{8'hA5});
        idle(1);
        send_seq('{8'h77});
        idle(8);
        check("drop_cnt2", drop_cnt, 2);
        check("drop_nwr", log_a.size(), 4);
        check("drop_a3", log_a[3], 8'h23);
        check("drop_d3", log_d[3], 8'h04);
        check("drop_busy", busy, 0);

        clear_logs();
        send_seq('{8'hA5, 8'h10});
        idle(LIMIT + 20);
        check("tmo_code", err_code, 3);
        check("tmo_gap", err_gap, LIMIT);
        check("tmo_busy", busy, 0);

        clear_logs();
        send_seq('{8'hA5, 8'h10, 8'h04, 8'h11});
        #2;
        rst = 0;
        #1;
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_code", err_code, 0);
        check("rst_mid_drop", drop_cnt, 0);
        check("rst_mid_addr", wr_addr, 0);
        @(posedge clk);
        #1;
        rst = 1;
        send_seq('{8'h22, 8'h33, 8'h44, 8'h20});
        idle(10);
        check("rst_mid_nwr", log_a.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
